match_scoreboard: RTL and testbench

MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

---
 rtl/match_scoreboard.sv | 134 +++++++++++++
 tb/tb_match_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/match_scoreboard.sv
// rtl/match_scoreboard.sv - round-by-round match scoreboard with win/lose/draw tally and game decision FSM
// Optional P1 win-streak tracking is enabled by defining SCOREBOARD_STREAK_EN.
module match_scoreboard #(
  parameter int CNT_W      = 4,
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             result_valid,
  input  logic [1:0]       matchresult,
  input  logic             new_game,
  output logic [CNT_W-1:0] round,
  output logic [CNT_W-1:0] win,
  output logic [CNT_W-1:0] lose,
  output logic [CNT_W-1:0] draw,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             reject,
  output logic [CNT_W-1:0] streak,
  output logic [CNT_W-1:0] best_streak
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TARGET  = CNT_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_ROUNDS);

  typedef enum logic [1:0] {PLAY, P1_WON, P2_WON, TIE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [CNT_W-1:0] round_nxt;
  logic [CNT_W-1:0] win_nxt;
  logic [CNT_W-1:0] lose_nxt;
  logic [CNT_W-1:0] draw_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] winner_code(input state_t s);
    case (s)
      P1_WON:  return 2'b01;
      P2_WON:  return 2'b11;
      TIE:     return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Decision uses the post-increment tallies so the deciding round takes effect at its own edge.
  always_comb begin
    accept    = result_valid && (matchresult != 2'b00);
    round_nxt = sat_inc(round);
    win_nxt   = (matchresult == 2'b01) ? sat_inc(win)  : win;
    lose_nxt  = (matchresult == 2'b11) ? sat_inc(lose) : lose;
    draw_nxt  = (matchresult == 2'b10) ? sat_inc(draw) : draw;
    state_nxt = PLAY;
    if (win_nxt == TARGET)
      state_nxt = P1_WON;
    else if (lose_nxt == TARGET)
      state_nxt = P2_WON;
    else if (round_nxt == LIMIT) begin
      if (win_nxt > lose_nxt)
        state_nxt = P1_WON;
      else if (lose_nxt > win_nxt)
        state_nxt = P2_WON;
      else
        state_nxt = TIE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= PLAY;
      round     <= '0;
      win       <= '0;
      lose      <= '0;
      draw      <= '0;
      game_over <= 1'b0;
      winner    <= 2'b00;
      reject    <= 1'b0;
    end else begin
      reject <= 1'b0;
      if (new_game) begin
        state     <= PLAY;
        round     <= '0;
        win       <= '0;
        lose      <= '0;
        draw      <= '0;
        game_over <= 1'b0;
        winner    <= 2'b00;
      end else if (accept) begin
        if (state == PLAY) begin
          round     <= round_nxt;
          win       <= win_nxt;
          lose      <= lose_nxt;
          draw      <= draw_nxt;
          state     <= state_nxt;
          game_over <= (state_nxt != PLAY);
          winner    <= winner_code(state_nxt);
        end else begin
          reject <= 1'b1;
        end
      end
    end
  end

`ifdef SCOREBOARD_STREAK_EN
  logic [CNT_W-1:0] streak_nxt;

  always_comb begin
    streak_nxt = (matchresult == 2'b01) ? sat_inc(streak) : '0;
  end

  // best_streak deliberately survives new_game; only resetn clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak      <= '0;
      best_streak <= '0;
    end else if (new_game) begin
      streak <= '0;
    end else if (accept && state == PLAY) begin
      streak <= streak_nxt;
      if (streak_nxt > best_streak)
        best_streak <= streak_nxt;
    end
  end
`else
  assign streak      = '0;
  assign best_streak = '0;
`endif

endmodule

// File: tb/tb_match_scoreboard.sv
// tb/tb_match_scoreboard.sv - directed bench for match_scoreboard with a behavioural scoring model
// Streak expectations follow SCOREBOARD_STREAK_EN when it is defined for the build.
module tb_match_scoreboard;

  localparam int CNT_W = 4;
  localparam int T     = 3;
  localparam int MR    = 5;
  localparam int SAT   = 15;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             result_valid = 1'b0;
  logic [1:0]       matchresult = 2'b00;
  logic             new_game = 1'b0;
  logic [CNT_W-1:0] round, win, lose, draw, streak, best_streak;
  logic             game_over, reject;
  logic [1:0]       winner;

  int errors = 0;
  int checks = 0;

  int m_round = 0, m_win = 0, m_lose = 0, m_draw = 0;
  int m_over = 0, m_winner = 0, m_reject = 0, m_streak = 0, m_best = 0;

  match_scoreboard #(.CNT_W(CNT_W), .WIN_TARGET(T), .MAX_ROUNDS(MR)) dut (
    .clk(clk), .resetn(resetn), .result_valid(result_valid), .matchresult(matchresult),
    .new_game(new_game), .round(round), .win(win), .lose(lose), .draw(draw),
    .game_over(game_over), .winner(winner), .reject(reject),
    .streak(streak), .best_streak(best_streak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Game rules: first to T round wins takes it; at MR rounds the larger tally wins, equal is a tie.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_round = 0; m_win = 0; m_lose = 0; m_draw = 0;
      m_over = 0; m_winner = 0; m_reject = 0; m_streak = 0; m_best = 0;
    end else begin
      m_reject = 0;
      if (new_game) begin
        m_round = 0; m_win = 0; m_lose = 0; m_draw = 0;
        m_over = 0; m_winner = 0; m_streak = 0;
      end else if (result_valid && matchresult != 2'b00) begin
        if (m_over != 0) begin
          m_reject = 1;
        end else begin
          m_round = inc(m_round);
          if (matchresult == 2'b01) m_win = inc(m_win);
          else if (matchresult == 2'b11) m_lose = inc(m_lose);
          else m_draw = inc(m_draw);
          if (m_win == T) begin
            m_over = 1; m_winner = 1;
          end else if (m_lose == T) begin
            m_over = 1; m_winner = 3;
          end else if (m_round == MR) begin
            m_over = 1;
            m_winner = (m_win > m_lose) ? 1 : (m_lose > m_win) ? 3 : 2;
          end
`ifdef SCOREBOARD_STREAK_EN
          m_streak = (matchresult == 2'b01) ? inc(m_streak) : 0;
          if (m_streak > m_best) m_best = m_streak;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("round", int'(round), m_round);
    chk("win", int'(win), m_win);
    chk("lose", int'(lose), m_lose);
    chk("draw", int'(draw), m_draw);
    chk("game_over", int'(game_over), m_over);
    chk("winner", int'(winner), m_winner);
    chk("reject", int'(reject), m_reject);
    chk("streak", int'(streak), m_streak);
    chk("best_streak", int'(best_streak), m_best);
  end

  task automatic drive(input logic v, input logic [1:0] c, input logic ng);
    result_valid = v;
    matchresult  = c;
    new_game     = ng;
    @(negedge clk);
    result_valid = 1'b0;
    matchresult  = 2'b00;
    new_game     = 1'b0;
  endtask

  task automatic strobe(input logic [1:0] c);
    drive(1'b1, c, 1'b0);
  endtask

  task automatic start_game();
    drive(1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_round", int'(round), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_best", int'(best_streak), 0);
    resetn = 1'b1;
    @(negedge clk);

    strobe(2'b01); strobe(2'b01); strobe(2'b01);
    chk("a_win", int'(win), 3);
    chk("a_round", int'(round), 3);
    chk("a_over", int'(game_over), 1);
    chk("a_winner", int'(winner), 1);
    strobe(2'b11);
    chk("a_reject", int'(reject), 1);
    chk("a_lose", int'(lose), 0);
    drive(1'b0, 2'b00, 1'b0);
    chk("a_reject_end", int'(reject), 0);
    strobe(2'b10);
    chk("a_reject_draw", int'(reject), 1);
    chk("a_draw_held", int'(draw), 0);
    start_game();
    chk("ng_over", int'(game_over), 0);
    chk("ng_winner", int'(winner), 0);
    chk("ng_round", int'(round), 0);

    strobe(2'b01); strobe(2'b11); strobe(2'b10); strobe(2'b11); strobe(2'b10);
    chk("b_round", int'(round), 5);
    chk("b_win", int'(win), 1);
    chk("b_lose", int'(lose), 2);
    chk("b_draw", int'(draw), 2);
    chk("b_winner", int'(winner), 3);
    chk("b_over", int'(game_over), 1);

    start_game();
    strobe(2'b01); strobe(2'b11); strobe(2'b10); strobe(2'b10);
    chk("c_over_early", int'(game_over), 0);
    strobe(2'b10);
    chk("c_win", int'(win), 1);
    chk("c_lose", int'(lose), 1);
    chk("c_round", int'(round), 5);
    chk("c_winner", int'(winner), 2);
    chk("c_over", int'(game_over), 1);

    start_game();
    strobe(2'b11); strobe(2'b11); strobe(2'b11);
    chk("d_winner", int'(winner), 3);
    chk("d_round", int'(round), 3);

    start_game();
    strobe(2'b01); strobe(2'b01);
`ifdef SCOREBOARD_STREAK_EN
    chk("e_streak2", int'(streak), 2);
`endif
    drive(1'b1, 2'b01, 1'b1);
    chk("e_round", int'(round), 0);
    chk("e_win", int'(win), 0);
    chk("e_reject", int'(reject), 0);
    chk("e_over", int'(game_over), 0);
    strobe(2'b00);
    chk("e_nores_round", int'(round), 0);
    chk("e_nores_reject", int'(reject), 0);

    strobe(2'b01); strobe(2'b11);
    chk("f_round2", int'(round), 2);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("f_async_round", int'(round), 0);
    chk("f_async_win", int'(win), 0);
    chk("f_async_lose", int'(lose), 0);
    @(negedge clk);
    resetn = 1'b1;
    strobe(2'b10);
    chk("f_first_round", int'(round), 1);
    chk("f_first_draw", int'(draw), 1);

    start_game();
    strobe(2'b01); strobe(2'b01); strobe(2'b10); strobe(2'b01);
    start_game();
    chk("g_streak", int'(streak), 0);
`ifdef SCOREBOARD_STREAK_EN
    chk("g_best", int'(best_streak), 2);
`else
    chk("g_best", int'(best_streak), 0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
